ps2_jump_receiver: RTL and testbench

- PS/2 keyboard receiver: the input-side counterpart of the VGA output controller, on the same ps2_clk/ps2_data pins that controller passes through.
- Filters and synchronises the PS/2 lines, deframes 11-bit device-to-host frames and reports each byte.
- Decodes make/break/extended prefixes and emits a one-cycle `jump` pulse on a fresh press of the jump key; this is the game's `jump` input.
- Receive-only: the host-to-device direction is never driven.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_jump_receiver.sv | 176 +++++++++++++++++
 tb/tb_ps2_jump_receiver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, frame FSM state encoding and parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_SPACE = 8'h29;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  // PS/2 uses odd parity across the data byte and the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line front end: 2-FF synchronisers, clock glitch filter and registered falling-edge pulse.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_meta;
  logic [1:0]    data_meta;
  logic [CW-1:0] cnt;
  logic          clk_filt;

  // Lines idle high, so the synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
      cnt       <= '0;
      clk_filt  <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_meta  <= {clk_meta[0], ps2_clk};
      data_meta <= {data_meta[0], ps2_data};
      fall      <= 1'b0;
      if (clk_meta[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt      <= '0;
        clk_filt <= clk_meta[1];
        fall     <= clk_filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_jump_receiver.sv
// PS/2 keyboard receiver: deframes device-to-host frames and turns jump-key makes into pulses.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a falling edge)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, reporting the byte
module ps2_jump_receiver
  import ps2_pkg::*;
#(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 20000,
  parameter logic [7:0] JUMP_SCANCODE  = PS2_SPACE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       jump,
  output logic       key_held
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall;
  logic data_s;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_sync(data_s)
  );

  frame_state_t   state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [7:0]     rx_data_d;
  logic           rx_valid_d;
  logic           parity_err_d;
  logic           frame_err_d;
  logic           timeout;

  // A falling edge always wins over an expiring watchdog in the same cycle.
  assign timeout = (state_q != IDLE) && !fall && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    wd_d         = '0;
    rx_data_d    = rx_data;
    rx_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q != IDLE && !fall) begin
      wd_d = wd_q + WDW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!data_s) begin
            frame_err_d = 1'b1;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            parity_err_d = 1'b1;
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d     = IDLE;
      wd_d        = '0;
      bit_cnt_d   = '0;
      shift_d     = '0;
      frame_err_d = 1'b1;
    end
  end

  logic brk_q;
  logic ext_q;

  // Prefix flags persist across errored frames; the next good byte resolves them.
  always_ff @(posedge clk) begin
    if (reset) begin
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      key_held <= 1'b0;
      jump     <= 1'b0;
    end else begin
      jump <= 1'b0;
      if (rx_valid) begin
        if (rx_data == PS2_BREAK) begin
          brk_q <= 1'b1;
        end else if (rx_data == PS2_EXT) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (!ext_q && rx_data == JUMP_SCANCODE) begin
            if (brk_q) begin
              key_held <= 1'b0;
            end else if (!key_held) begin
              jump     <= 1'b1;
              key_held <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_jump_receiver.sv
// Directed bench for ps2_jump_receiver with a pulse scoreboard fed by a small decoder model.
module tb_ps2_jump_receiver;
  import ps2_pkg::*;

  localparam int FL   = 4;
  localparam int TO   = 2000;
  localparam int HALF = 200;

  localparam logic [3:0] K_RX  = 4'b1000;
  localparam logic [3:0] K_PE  = 4'b0100;
  localparam logic [3:0] K_FE  = 4'b0010;
  localparam logic [3:0] K_JMP = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       jump;
  logic       key_held;

  ps2_jump_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO),
    .JUMP_SCANCODE (8'h29)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .jump      (jump),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   m_brk = 1'b0;
  bit   m_ext = 1'b0;
  bit   m_held = 1'b0;
  logic prev_rx_valid = 1'b0;
  logic [3:0] obs_kind;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Every output pulse cycle consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (reset) begin
      prev_rx_valid = 1'b0;
    end else begin
      obs_kind = {rx_valid, parity_err, frame_err, jump};
      if (obs_kind != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(obs_kind), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 32'(obs_kind), 32'(e.kind));
          if (e.kind == K_RX) check("rx_data", 32'(rx_data), 32'(e.data));
          if (e.kind == K_JMP) check("jump_latency", 32'(prev_rx_valid), 32'h1);
        end
      end
      prev_rx_valid = rx_valid;
    end
  end

  task automatic push_ev(input logic [3:0] kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_ev(K_RX, b);
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      if (!m_ext && b == 8'h29) begin
        if (m_brk) begin
          m_held = 1'b0;
        end else if (!m_held) begin
          push_ev(K_JMP, 8'h00);
          m_held = 1'b1;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < PS2_FRAME_LEN; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic good_frame(input logic [7:0] b);
    push_byte(b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] stall_byte;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_pulses", 32'({rx_valid, parity_err, frame_err, jump}), 32'h0);
    check("reset_key_held", 32'(key_held), 32'h0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    repeat (10) @(negedge clk);

    good_frame(8'h29);
    check("first_press_held", 32'(key_held), 32'h1);

    good_frame(8'h29);
    good_frame(8'h29);
    check("typematic_held", 32'(key_held), 32'h1);

    good_frame(8'hF0);
    good_frame(8'h29);
    check("release_held", 32'(key_held), 32'h0);
    good_frame(8'h29);
    check("repress_held", 32'(key_held), 32'h1);

    good_frame(8'hE0);
    good_frame(8'h29);
    check("ext_held", 32'(key_held), 32'h1);
    good_frame(8'h1C);
    check("other_key_data", 32'(rx_data), 32'h1C);

    push_ev(K_PE, 8'h00);
    send_frame(8'h29, 1'b1, 1'b1);
    check("parity_keeps_data", 32'(rx_data), 32'h1C);
    push_ev(K_FE, 8'h00);
    send_frame(8'h29, 1'b0, 1'b0);
    check("stop_keeps_data", 32'(rx_data), 32'h1C);
    check("errors_keep_held", 32'(key_held), 32'h1);

    push_ev(K_FE, 8'h00);
    stall_byte = 8'h29;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(stall_byte[i]);
    ps2_data = 1'b1;
    repeat (3000) @(negedge clk);
    check("stall_idle", 32'(dut.state_q), 32'(IDLE));

    // Glitch with data low: a spurious edge would look like a start bit.
    ps2_data = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);

    good_frame(8'h29);
    check("post_glitch_data", 32'(rx_data), 32'h29);
    check("post_glitch_held", 32'(key_held), 32'h1);

    repeat (50) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
